fpu_ss_xif_arbiter: RTL

Parametrised N-core front end for one shared `fpu_ss` instance. Each core keeps its own CORE-V-XIF issue and result channels. The block round-robin arbitrates the issue channels onto the single FPU issue port. It renames each core transaction ID to an internal tag drawn from a free list, and routes every FPU result back to the originating core with the core's original ID restored. Commit and memory interfaces are not routed by this block.

---
 rtl/fpu_ss_xif_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_ss_xif_arbiter.sv
// N-core CORE-V-XIF front end for a shared fpu_ss: round-robin issue arbitration,
// core-ID to internal-tag renaming through a free list, and result routing back to cores.
module fpu_ss_xif_arbiter #(
    parameter int NB_CORES   = 8,
    parameter int ID_WIDTH   = 4,
    parameter int TAG_DEPTH  = 4,
    parameter int DATA_WIDTH = 32,
    localparam int TAG_WIDTH = $clog2(TAG_DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,

    input  logic [NB_CORES-1:0]              core_issue_valid_i,
    output logic [NB_CORES-1:0]              core_issue_ready_o,
    input  logic [NB_CORES*32-1:0]           core_issue_instr_i,
    input  logic [NB_CORES*ID_WIDTH-1:0]     core_issue_id_i,
    input  logic [NB_CORES*2*DATA_WIDTH-1:0] core_issue_rs_i,
    output logic [NB_CORES-1:0]              core_issue_accept_o,

    output logic                             fpu_issue_valid_o,
    input  logic                             fpu_issue_ready_i,
    output logic [31:0]                      fpu_issue_instr_o,
    output logic [TAG_WIDTH-1:0]             fpu_issue_id_o,
    output logic [2*DATA_WIDTH-1:0]          fpu_issue_rs_o,
    input  logic                             fpu_issue_accept_i,

    input  logic                             fpu_result_valid_i,
    output logic                             fpu_result_ready_o,
    input  logic [TAG_WIDTH-1:0]             fpu_result_id_i,
    input  logic [DATA_WIDTH-1:0]            fpu_result_data_i,
    input  logic [4:0]                       fpu_result_rd_i,
    input  logic                             fpu_result_we_i,

    output logic [NB_CORES-1:0]              core_result_valid_o,
    input  logic [NB_CORES-1:0]              core_result_ready_i,
    output logic [ID_WIDTH-1:0]              core_result_id_o,
    output logic [DATA_WIDTH-1:0]            core_result_data_o,
    output logic [4:0]                       core_result_rd_o,
    output logic                             core_result_we_o,

    output logic [TAG_WIDTH:0]               outstanding_o,
    output logic                             err_o
);

    localparam int CORE_WIDTH = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    logic [CORE_WIDTH-1:0] rr_q;
    logic                  lock_q;
    logic [CORE_WIDTH-1:0] lock_core_q;
    logic [TAG_DEPTH-1:0]  tag_valid_q;
    logic [CORE_WIDTH-1:0] tag_core_q [TAG_DEPTH];
    logic [ID_WIDTH-1:0]   tag_id_q   [TAG_DEPTH];
    logic [TAG_WIDTH:0]    outstanding_q;
    logic                  err_q;

    logic [TAG_WIDTH-1:0]  free_tag;
    logic                  table_full;
    logic [CORE_WIDTH-1:0] grant;
    logic [CORE_WIDTH-1:0] rr_next;
    logic                  any_req;
    logic                  issue_valid;
    logic                  issue_hs;
    logic                  alloc;
    logic                  entry_valid;
    logic [CORE_WIDTH-1:0] entry_core;
    logic                  release_tag;
    logic                  bad_result;

    // Lowest free entry; the descending scan lets the smallest index win.
    always_comb begin
        free_tag = '0;
        for (int t = TAG_DEPTH - 1; t >= 0; t--) begin
            if (!tag_valid_q[t]) begin
                free_tag = TAG_WIDTH'(t);
            end
        end
    end

    assign table_full = &tag_valid_q;

    // A locked grant overrides the round-robin search so outputs stay stable until the handshake.
    always_comb begin
        grant   = rr_q;
        any_req = 1'b0;
        if (lock_q) begin
            grant   = lock_core_q;
            any_req = core_issue_valid_i[lock_core_q];
        end else begin
            for (int i = NB_CORES - 1; i >= 0; i--) begin
                automatic int                    idx;
                automatic logic [CORE_WIDTH-1:0] cand;
                idx = int'(rr_q) + i;
                if (idx >= NB_CORES) begin
                    idx = idx - NB_CORES;
                end
                cand = CORE_WIDTH'(idx);
                if (core_issue_valid_i[cand]) begin
                    grant   = cand;
                    any_req = 1'b1;
                end
            end
        end
    end

    assign issue_valid       = any_req & ~table_full;
    assign issue_hs          = issue_valid & fpu_issue_ready_i;
    assign alloc             = issue_hs & fpu_issue_accept_i;
    assign rr_next           = (grant == CORE_WIDTH'(NB_CORES - 1)) ? '0 : grant + 1'b1;

    assign fpu_issue_valid_o = issue_valid;
    assign fpu_issue_instr_o = core_issue_instr_i[grant*32 +: 32];
    assign fpu_issue_rs_o    = core_issue_rs_i[grant*2*DATA_WIDTH +: 2*DATA_WIDTH];
    assign fpu_issue_id_o    = free_tag;

    always_comb begin
        core_issue_ready_o  = '0;
        core_issue_accept_o = '0;
        if (issue_valid) begin
            core_issue_ready_o[grant]  = fpu_issue_ready_i;
            core_issue_accept_o[grant] = fpu_issue_accept_i;
        end
    end

    assign entry_valid = tag_valid_q[fpu_result_id_i];
    assign entry_core  = tag_core_q[fpu_result_id_i];

    // Results for unallocated tags are swallowed so a stale tag can never stall the FPU.
    always_comb begin
        core_result_valid_o = '0;
        fpu_result_ready_o  = 1'b1;
        if (entry_valid) begin
            core_result_valid_o[entry_core] = fpu_result_valid_i;
            fpu_result_ready_o              = core_result_ready_i[entry_core];
        end
    end

    assign release_tag        = fpu_result_valid_i & entry_valid & core_result_ready_i[entry_core];
    assign bad_result         = fpu_result_valid_i & ~entry_valid;

    assign core_result_id_o   = tag_id_q[fpu_result_id_i];
    assign core_result_data_o = fpu_result_data_i;
    assign core_result_rd_o   = fpu_result_rd_i;
    assign core_result_we_o   = fpu_result_we_i;
    assign outstanding_o      = outstanding_q;
    assign err_o              = err_q;

    // Allocation and release always target different entries, so both may land in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q          <= '0;
            lock_q        <= 1'b0;
            lock_core_q   <= '0;
            tag_valid_q   <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            for (int t = 0; t < TAG_DEPTH; t++) begin
                tag_core_q[t] <= '0;
                tag_id_q[t]   <= '0;
            end
        end else begin
            if (issue_hs) begin
                rr_q   <= rr_next;
                lock_q <= 1'b0;
            end else if (issue_valid) begin
                lock_q      <= 1'b1;
                lock_core_q <= grant;
            end
            if (alloc) begin
                tag_valid_q[free_tag] <= 1'b1;
                tag_core_q[free_tag]  <= grant;
                tag_id_q[free_tag]    <= core_issue_id_i[grant*ID_WIDTH +: ID_WIDTH];
            end
            if (release_tag) begin
                tag_valid_q[fpu_result_id_i] <= 1'b0;
            end
            if (alloc && !release_tag) begin
                outstanding_q <= outstanding_q + (TAG_WIDTH+1)'(1);
            end else if (!alloc && release_tag) begin
                outstanding_q <= outstanding_q - (TAG_WIDTH+1)'(1);
            end
            if (bad_result) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
